// File: rtl/evt2_uart_word_assembler_if.sv
// Byte-in / word-out stream bundle around the EVT2 word assembler.
//   rx_data/rx_valid : byte stream from uart_rx (1-cycle strobe)
//   word_out/valid   : head of the word FIFO (FWFT)
//   word_ready       : consumer accepts word_out when word_valid && word_ready
// slave  : the assembler (consumes bytes, produces words)
// master : the surrounding logic (feeds bytes, drains words)
interface evt2_uart_word_assembler_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport master (output rx_data, rx_valid, word_ready,
                  input  word_out, word_valid);
  modport slave  (input  rx_data, rx_valid, word_ready,
                  output word_out, word_valid);
endinterface

// File: rtl/evt2_uart_word_assembler.sv
// EVT2 word assembler: packs the MSB-first uart byte stream into 32-bit
// EVT2.0 words, splits off 0xFC-0xFF command bytes seen at a word boundary,
// and queues words in a small first-word-fall-through FIFO.
// An inter-byte timeout drops stale partial words so framing recovers after
// lost bytes; diagnostic counters saturate.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   flush         sync clear of FIFO + framer (counters kept)
//   bus           byte in / word out stream (slave side)
//   cmd_valid     1-cycle pulse, command byte seen
//   cmd_code      0=echo(FF) 1=status(FE) 2=config(FD) 3=reset(FC)
//   fill_level    words held in the FIFO
//   drop_count    words lost to a full FIFO
//   resync_count  partial words discarded by timeout
module evt2_uart_word_assembler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4167,
  parameter int CNT_W          = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  evt2_uart_word_assembler_if.slave     bus,
  output logic                          cmd_valid,
  output logic [1:0]                    cmd_code,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]              drop_count,
  output logic [CNT_W-1:0]              resync_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {B0, B1, B2, B3} fr_state_t;

  fr_state_t   state;
  logic [23:0] shift;          // first three bytes of the word in flight
  logic [TW-1:0] timer;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic is_cmd, timeout, full, pop, push_req, push, drop;
  logic [31:0] word_in;

  always_comb begin
    is_cmd   = (bus.rx_data[7:2] == 6'h3F);
    // a byte arriving on the expiry cycle wins over the timeout
    timeout  = (state != B0) && !bus.rx_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
    full     = (fill_level == (AW+1)'(FIFO_DEPTH));
    pop      = bus.word_valid && bus.word_ready;
    push_req = bus.rx_valid && (state == B3);
    // a same-cycle pop frees the slot, so a full FIFO can still take the word
    push     = push_req && (!full || pop);
    drop     = push_req && !push;
    word_in  = {shift, bus.rx_data};
  end

  assign bus.word_valid = (fill_level != '0);
  assign bus.word_out   = bus.word_valid ? mem[rd_ptr] : 32'h0;

  // Framer, timeout timer, command decode and diagnostic counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= B0;
      shift        <= '0;
      timer        <= '0;
      cmd_valid    <= 1'b0;
      cmd_code     <= 2'd0;
      drop_count   <= '0;
      resync_count <= '0;
    end else if (flush) begin
      // flush overrides any concurrent byte; counters deliberately kept
      state     <= B0;
      timer     <= '0;
      cmd_valid <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (bus.rx_valid) begin
        timer <= '0;
        unique case (state)
          B0: if (is_cmd) begin
                cmd_valid <= 1'b1;
                cmd_code  <= ~bus.rx_data[1:0];
              end else begin
                shift[23:16] <= bus.rx_data;
                state        <= B1;
              end
          B1: begin shift[15:8] <= bus.rx_data; state <= B2; end
          B2: begin shift[7:0]  <= bus.rx_data; state <= B3; end
          B3: state <= B0;     // word leaves here whether or not it fit
        endcase
      end else if (timeout) begin
        state <= B0;
        timer <= '0;
        if (resync_count != '1) resync_count <= resync_count + 1'b1;
      end else if (state == B0) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  // FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible unless fill_level says so
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= word_in;
  end
endmodule

// File: tb/tb_evt2_uart_word_assembler.sv
module tb_evt2_uart_word_assembler;
  localparam int D = 4;
  localparam int T = 4167;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cmd_valid;
  logic [1:0] cmd_code;
  logic [$clog2(D):0] fill_level;
  logic [7:0] drop_count, resync_count;

  int errors = 0;
  int checks = 0;

  evt2_uart_word_assembler_if bus ();

  evt2_uart_word_assembler #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .fill_level(fill_level),
    .drop_count(drop_count), .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  // Called at a negedge; leaves the byte sampled and returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic test_reset;
    checks++; if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %b want 0", bus.word_valid); end
    checks++; if (bus.word_out !== 32'h0) begin errors++; $display("FAIL reset_word_out got %h want 0", bus.word_out); end
    checks++; if (cmd_valid !== 1'b0 || cmd_code !== 2'd0) begin errors++; $display("FAIL reset_cmd got %b/%0d want 0/0", cmd_valid, cmd_code); end
    checks++; if (fill_level !== 0 || drop_count !== 0 || resync_count !== 0) begin errors++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", fill_level, drop_count, resync_count); end
  endtask

  task automatic test_basic_word;
    bus.word_ready = 1'b1;
    send_word(32'h12345678);
    checks++; if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h12345678) begin errors++; $display("FAIL basic_word got %b %h want 1 12345678", bus.word_valid, bus.word_out); end
    @(negedge clk);
    checks++; if (fill_level !== 0 || bus.word_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got fill %0d valid %b want 0 0", fill_level, bus.word_valid); end
  endtask

  task automatic test_cmd;
    logic [7:0] bytes [4];
    logic [1:0] codes [4];
    bytes = '{8'hFE, 8'hFF, 8'hFD, 8'hFC};
    codes = '{2'd1, 2'd0, 2'd2, 2'd3};
    bus.word_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== codes[i]) begin errors++; $display("FAIL cmd_%h got %b/%0d want 1/%0d", bytes[i], cmd_valid, cmd_code, codes[i]); end
      @(negedge clk);
      checks++; if (cmd_valid !== 1'b0 || fill_level !== 0) begin errors++; $display("FAIL cmd_pulse_%h got valid %b fill %0d want 0 0", bytes[i], cmd_valid, fill_level); end
    end
    // 0xFF inside a word is data
    send_byte(8'h20); send_byte(8'hFF);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL cmd_in_word got %b want 0", cmd_valid); end
    send_byte(8'h00); send_byte(8'h01);
    checks++; if (bus.word_out !== 32'h20FF0001 || fill_level !== 1) begin errors++; $display("FAIL data_ff_word got %h fill %0d want 20ff0001 1", bus.word_out, fill_level); end
    bus.word_ready = 1'b1; @(negedge clk); bus.word_ready = 1'b0;
  endtask

  task automatic test_fifo_full;
    logic [31:0] w;
    bus.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word({8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)});
    checks++; if (fill_level !== 4 || drop_count !== 1) begin errors++; $display("FAIL full got fill %0d drop %0d want 4 1", fill_level, drop_count); end
    for (int i = 0; i < 4; i++) begin
      w = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)};
      checks++; if (bus.word_valid !== 1'b1 || bus.word_out !== w) begin errors++; $display("FAIL drain_%0d got %b %h want 1 %h", i, bus.word_valid, bus.word_out, w); end
      bus.word_ready = 1'b1; @(negedge clk);
    end
    bus.word_ready = 1'b0;
    checks++; if (bus.word_valid !== 1'b0 || fill_level !== 0) begin errors++; $display("FAIL drain_empty got %b fill %0d want 0 0", bus.word_valid, fill_level); end
  endtask

  task automatic test_back_to_back_push_pop;
    logic [31:0] exp [4];
    exp = '{32'hB1000001, 32'hB2000002, 32'hB3000003, 32'hC0DE0006};
    bus.word_ready = 1'b0;
    send_word(32'hB0000000); send_word(32'hB1000001);
    send_word(32'hB2000002); send_word(32'hB3000003);
    send_byte(8'hC0); send_byte(8'hDE); send_byte(8'h00);
    bus.word_ready = 1'b1;
    send_byte(8'h06);
    bus.word_ready = 1'b0;
    checks++; if (fill_level !== 4 || drop_count !== 1) begin errors++; $display("FAIL pushpop got fill %0d drop %0d want 4 1", fill_level, drop_count); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.word_out !== exp[i]) begin errors++; $display("FAIL pushpop_drain_%0d got %h want %h", i, bus.word_out, exp[i]); end
      bus.word_ready = 1'b1; @(negedge clk);
    end
    bus.word_ready = 1'b0;
  endtask

  task automatic test_timeout;
    bus.word_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (T - 1) @(negedge clk);
    checks++; if (resync_count !== 0) begin errors++; $display("FAIL timeout_early got %0d want 0", resync_count); end
    @(negedge clk);
    checks++; if (resync_count !== 1) begin errors++; $display("FAIL timeout got %0d want 1", resync_count); end
    send_word(32'h01020304);
    checks++; if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h01020304) begin errors++; $display("FAIL resync_word got %b %h want 1 01020304", bus.word_valid, bus.word_out); end
    @(negedge clk);
  endtask

  task automatic test_byte_on_timeout;
    bus.word_ready = 1'b1;
    send_byte(8'h55); send_byte(8'h66);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h77);
    send_byte(8'h88);
    checks++; if (bus.word_out !== 32'h55667788 || resync_count !== 1) begin errors++; $display("FAIL edge_timeout got %h resync %0d want 55667788 1", bus.word_out, resync_count); end
    @(negedge clk);
  endtask

  task automatic test_flush;
    bus.word_ready = 1'b0;
    send_word(32'hF1F1F1F1); send_word(32'hF2F2F2F2); send_word(32'hF3F3F3F3);
    send_byte(8'hAB); send_byte(8'hCD);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    checks++; if (bus.word_valid !== 1'b0 || fill_level !== 0 || bus.word_out !== 32'h0) begin errors++; $display("FAIL flush got valid %b fill %0d out %h want 0 0 0", bus.word_valid, fill_level, bus.word_out); end
    checks++; if (drop_count !== 1 || resync_count !== 1) begin errors++; $display("FAIL flush_counters got %0d %0d want 1 1", drop_count, resync_count); end
    send_word(32'h11223344);
    checks++; if (bus.word_out !== 32'h11223344 || fill_level !== 1) begin errors++; $display("FAIL flush_reframe got %h fill %0d want 11223344 1", bus.word_out, fill_level); end
    bus.word_ready = 1'b1; @(negedge clk); bus.word_ready = 1'b0;
  endtask

  task automatic test_async_reset;
    bus.word_ready = 1'b0;
    send_word(32'hDEADBEEF);
    send_byte(8'h99);
    send_byte(8'hFE);            // data in B1, then reset mid-word
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.word_valid !== 1'b0 || bus.word_out !== 32'h0 || fill_level !== 0) begin errors++; $display("FAIL async_fifo got %b %h %0d want 0 0 0", bus.word_valid, bus.word_out, fill_level); end
    checks++; if (drop_count !== 0 || resync_count !== 0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL async_counters got %0d %0d %b want 0 0 0", drop_count, resync_count, cmd_valid); end
    @(negedge clk); rst_n = 1'b1;
    send_word(32'hCAFE0102);
    checks++; if (bus.word_out !== 32'hCAFE0102 || fill_level !== 1) begin errors++; $display("FAIL async_reframe got %h fill %0d want cafe0102 1", bus.word_out, fill_level); end
  endtask

  initial begin
    bus.rx_data = 8'h0; bus.rx_valid = 1'b0; bus.word_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic_word;
    test_cmd;
    test_fifo_full;
    test_back_to_back_push_pop;
    test_timeout;
    test_byte_on_timeout;
    test_flush;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
